opcode_match_unit: RTL and testbench
====================================

Name: opcode_match_unit

Overview:
- Parametrised, pipelined successor to the single 6-bit opcode equality detector in the MIPS decode path.
- Compares each incoming WIDTH-bit field against NUM_PAT software-programmable (value, mask) patterns.
- Produces a registered one-hot hit vector, a priority-encoded index and per-pattern saturating hit counters.
- Sits between instruction fetch and control decode; uses a valid/ready handshake so decode stalls propagate back.

Parameters:
- WIDTH, 6: compared field width in bits (opcode/funct).
- NUM_PAT, 8: number of pattern entries (≥1).
- IDX_W, 3: index width; equals clog2(NUM_PAT), minimum 1.
- CNT_W, 16: width of each hit counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- cfg_we, input, 1: pattern write strobe.
- cfg_idx, input, IDX_W: entry to write.
- cfg_value, input, WIDTH: pattern value.
- cfg_mask, input, WIDTH: 1 = bit compared, 0 = don't-care.
- cfg_en, input, 1: entry enable.
- in_valid, input, 1: input field valid.
- in_ready, output, 1: unit can accept input.
- in_field, input, WIDTH: field to classify.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- out_hit, output, 1: at least one enabled entry matched.
- out_idx, output, IDX_W: lowest matching entry index; 0 when no hit.
- out_onehot, output, NUM_PAT: per-entry match vector.
- cnt_sel, input, IDX_W: counter read select.
- cnt_clr, input, 1: clear the selected counter.
- cnt_val, output, CNT_W: combinational read of the selected counter.

Behaviour:
- Reset (rst_n low, asynchronous): all entries value=0, mask=0, en=0; out_valid=0, out_hit=0, out_idx=0, out_onehot=0; all counters 0. in_ready=1 once reset releases.
- Match rule: entry i matches when en[i]=1 and ((in_field XOR value[i]) AND mask[i]) == 0. An enabled entry with mask=0 matches everything.
- Pipeline: single output register stage, latency 1 cycle.
- in_ready = !out_valid || out_ready, purely combinational. No skid buffer.
- Input accepted on an edge where in_valid && in_ready. The result register loads on that edge and out_valid is set to 1.
- When out_valid && out_ready with no new accept: out_valid clears to 0; the other output fields hold their last value.
- out_valid high && out_ready low: all outputs hold stable; in_ready=0.
- Priority: out_idx is the lowest i with out_onehot[i]=1.
- Config write: takes effect on the clock edge. A compare accepted on the same edge uses the pre-write entry contents. cfg_idx ≥ NUM_PAT is ignored.
- Counters: on each accepted input, every matching entry's counter increments by 1. Counters saturate at 2^CNT_W−1 (no wrap).
- Counter clear: cnt_clr zeroes counter[cnt_sel] on the edge. If clear and increment hit the same counter on the same edge, clear wins (result 0). cnt_sel ≥ NUM_PAT reads 0.
- Counters count accepted inputs, not output handshakes.
- Disabled entries never match and never count. Their stored value/mask are retained.
- Reset mid-transfer: any in-flight result is dropped; out_valid=0 immediately (asynchronous).

Decomposition:
- Shared package (mips_pkg):
  - Opcode constants: OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_LW=6'h23, OP_SW=6'h2B.
  - Default WIDTH, and a clog2 function for IDX_W.
- Sub-module pattern_cmp: combinational masked equality of one entry (XOR per bit, AND with mask, NOR-reduce, gated by en). Instantiated NUM_PAT times via generate.

Test Plan:
- Exact match: program entry0=(0x23, mask 0x3F), entry1=(0x2B, mask 0x3F), both enabled. Send 0x2B with out_ready=1 → next cycle out_valid=1, out_hit=1, out_idx=1, out_onehot=8'b00000010; counter1=1.
- Masked overlap and priority: entry2=(0x20, mask 0x30). Send 0x23 → out_onehot=8'b00000101, out_idx=0; counters 0 and 2 increment.
- Backpressure: out_ready=0 after one accept → in_ready=0; out_idx/out_onehot stable for 5 cycles. Raise out_ready → a new input is accepted that same cycle.
- Write/compare collision: same edge writes entry0=(0x04, 0x3F) and accepts 0x04 → out_hit=0 (old entry used). Resend 0x04 → out_hit=1, out_idx=0.
- Counter saturation and clear: CNT_W=4 build, 20 hits on entry0 → cnt_val=15. Assert cnt_clr together with a hit on the same edge → cnt_val=0.
- Async reset: drop rst_n mid-cycle while out_valid=1 → out_valid=0 without a clock edge. After release, no entry matches 0x00 (out_hit=0).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and elaboration helpers for the opcode matcher.
package mips_pkg;

  localparam int DEFAULT_WIDTH = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Index width for n entries; a single entry still needs one index bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pattern_cmp.sv
// Masked equality of one pattern entry against the incoming field (combinational).
module pattern_cmp #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] field,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] mask,
  input  logic             en,
  output logic             hit
);

  logic [WIDTH-1:0] diff;

  assign diff = (field ^ value) & mask;
  assign hit  = en & ~(|diff);

endmodule

// File: rtl/opcode_match_unit.sv
// Classifies fields against programmable (value, mask) patterns with hit counters.
// One registered stage (latency 1); in_ready drops while a held result is unconsumed.
module opcode_match_unit
  import mips_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_PAT = 8,
  parameter int IDX_W   = clog2_min1(NUM_PAT),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [WIDTH-1:0]   cfg_value,
  input  logic [WIDTH-1:0]   cfg_mask,
  input  logic               cfg_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_field,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_hit,
  output logic [IDX_W-1:0]   out_idx,
  output logic [NUM_PAT-1:0] out_onehot,
  input  logic [IDX_W-1:0]   cnt_sel,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt_val
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]   pat_value [NUM_PAT];
  logic [WIDTH-1:0]   pat_mask  [NUM_PAT];
  logic [NUM_PAT-1:0] pat_en;
  logic [CNT_W-1:0]   cnt_q     [NUM_PAT];

  logic [NUM_PAT-1:0] match;
  logic [IDX_W-1:0]   match_idx;
  logic               accept;
  logic               cfg_ok;
  logic               sel_ok;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign cfg_ok   = int'(cfg_idx) < NUM_PAT;
  assign sel_ok   = int'(cnt_sel) < NUM_PAT;

  for (genvar g = 0; g < NUM_PAT; g++) begin : g_cmp
    pattern_cmp #(.WIDTH(WIDTH)) u_cmp (
      .field (in_field),
      .value (pat_value[g]),
      .mask  (pat_mask[g]),
      .en    (pat_en[g]),
      .hit   (match[g])
    );
  end

  // Walk from the top down so the lowest matching entry is the one that sticks.
  always_comb begin
    match_idx = '0;
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (match[i]) match_idx = IDX_W'(i);
    end
  end

  // Compares read the pre-edge table, so a same-edge write only affects later inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_en <= '0;
      for (int i = 0; i < NUM_PAT; i++) begin
        pat_value[i] <= '0;
        pat_mask[i]  <= '0;
      end
    end else if (cfg_we && cfg_ok) begin
      pat_value[cfg_idx] <= cfg_value;
      pat_mask[cfg_idx]  <= cfg_mask;
      pat_en[cfg_idx]    <= cfg_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_hit    <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_hit    <= |match;
      out_idx    <= match_idx;
      out_onehot <= match;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Clear outranks a same-edge increment on the selected counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PAT; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PAT; i++) begin
        if (cnt_clr && sel_ok && (int'(cnt_sel) == i)) begin
          cnt_q[i] <= '0;
        end else if (accept && match[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_val = sel_ok ? cnt_q[cnt_sel] : '0;

endmodule

// File: tb/tb_opcode_match_unit.sv
module tb_opcode_match_unit;
  import mips_pkg::*;

  localparam int W  = 6;
  localparam int NP = 8;
  localparam int IW = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [W-1:0]  cfg_value;
  logic [W-1:0]  cfg_mask;
  logic          cfg_en;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_field;
  logic          out_valid;
  logic          out_ready;
  logic          out_hit;
  logic [IW-1:0] out_idx;
  logic [NP-1:0] out_onehot;
  logic [IW-1:0] cnt_sel;
  logic          cnt_clr;
  logic [CW-1:0] cnt_val;

  opcode_match_unit #(.WIDTH(W), .NUM_PAT(NP), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_field(in_field),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_idx(out_idx), .out_onehot(out_onehot),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_val(cnt_val)
  );

  always #5 clk = ~clk;

  // Reference model: pattern table, counters and the expected output register.
  int   mv [NP];
  int   mm [NP];
  bit   me [NP];
  int   mc [NP];
  bit   e_valid;
  bit   e_hit;
  int   e_idx;
  int   e_oh;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mv[i] = 0; mm[i] = 0; me[i] = 0; mc[i] = 0;
    end
    e_valid = 0; e_hit = 0; e_idx = 0; e_oh = 0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".out_valid"},  out_valid,  e_valid);
    chk({where, ".out_hit"},    out_hit,    e_hit);
    chk({where, ".out_idx"},    out_idx,    e_idx);
    chk({where, ".out_onehot"}, out_onehot, e_oh);
    chk({where, ".cnt_val"},    cnt_val,    mc[cnt_sel]);
  endtask

  // Inputs are set by the caller; predict the edge, take it, compare.
  task automatic tick(input string where);
    bit acc;
    int hv;
    #1;
    chk({where, ".in_ready"}, in_ready, (!e_valid || out_ready));
    acc = in_valid && (!e_valid || out_ready);
    hv = 0;
    for (int i = 0; i < NP; i++)
      if (me[i] && (((int'(in_field) ^ mv[i]) & mm[i]) == 0)) hv |= (1 << i);
    if (acc) begin
      e_valid = 1;
      e_oh    = hv;
      e_hit   = (hv != 0);
      e_idx   = 0;
      for (int i = NP - 1; i >= 0; i--) if (hv & (1 << i)) e_idx = i;
      for (int i = 0; i < NP; i++) if ((hv & (1 << i)) && mc[i] < CMAX) mc[i]++;
    end else if (e_valid && out_ready) begin
      e_valid = 0;
    end
    if (cnt_clr) mc[cnt_sel] = 0;
    if (cfg_we) begin
      mv[cfg_idx] = cfg_value; mm[cfg_idx] = cfg_mask; me[cfg_idx] = cfg_en;
    end
    @(posedge clk);
    #1;
    check_outputs(where);
  endtask

  task automatic cfg_write(input int idx, input int val, input int msk, input bit en);
    cfg_we = 1; cfg_idx = IW'(idx); cfg_value = W'(val); cfg_mask = W'(msk); cfg_en = en;
    in_valid = 0;
    tick("cfg");
    cfg_we = 0;
  endtask

  task automatic send(input string where, input logic [W-1:0] f);
    in_valid = 1; in_field = f;
    tick(where);
    in_valid = 0;
  endtask

  initial begin
    rst_n = 0; cfg_we = 0; cfg_idx = 0; cfg_value = 0; cfg_mask = 0; cfg_en = 0;
    in_valid = 0; in_field = 0; out_ready = 1; cnt_sel = 0; cnt_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst.in_ready", in_ready, 1);
    check_outputs("rst");

    // Exact match
    cfg_write(0, OP_LW, 6'h3F, 1);
    cfg_write(1, OP_SW, 6'h3F, 1);
    cnt_sel = 1;
    send("exact", OP_SW);
    chk("exact.tp_onehot", out_onehot, 8'b0000_0010);
    chk("exact.tp_idx", out_idx, 1);
    chk("exact.tp_cnt1", cnt_val, 1);

    // Masked overlap and priority
    cfg_write(2, 6'h20, 6'h30, 1);
    cnt_sel = 2;
    send("prio", OP_LW);
    chk("prio.tp_onehot", out_onehot, 8'b0000_0101);
    chk("prio.tp_idx", out_idx, 0);
    chk("prio.tp_cnt2", cnt_val, 1);
    cnt_sel = 0;
    tick("prio_cnt0");
    chk("prio.tp_cnt0", cnt_val, 1);

    // Backpressure
    out_ready = 0;
    send("bp_acc", OP_SW);
    in_valid = 1; in_field = OP_LW;
    for (int k = 0; k < 5; k++) begin
      tick("bp_hold");
      chk("bp.tp_in_ready", in_ready, 0);
      chk("bp.tp_idx_stable", out_idx, 1);
    end
    out_ready = 1;
    tick("bp_release");
    chk("bp.tp_new_idx", out_idx, 0);
    in_valid = 0;
    tick("bp_drain");

    // Write/compare collision
    cfg_we = 1; cfg_idx = 0; cfg_value = OP_BEQ; cfg_mask = 6'h3F; cfg_en = 1;
    send("coll_same", OP_BEQ);
    cfg_we = 0;
    chk("coll.tp_old_miss", out_hit, 0);
    send("coll_again", OP_BEQ);
    chk("coll.tp_hit", out_hit, 1);
    chk("coll.tp_idx", out_idx, 0);

    // Counter saturation and clear
    cnt_sel = 0;
    for (int k = 0; k < 20; k++) send("sat", OP_BEQ);
    chk("sat.tp_cnt", cnt_val, CMAX);
    cnt_clr = 1;
    send("clr_hit", OP_BEQ);
    cnt_clr = 0;
    chk("clr.tp_cnt", cnt_val, 0);

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_idx   = IW'($urandom_range(0, NP - 1));
      cfg_value = W'($urandom);
      cfg_mask  = ($urandom_range(0, 3) == 0) ? W'($urandom) : 6'h3F;
      cfg_en    = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1);
      case ($urandom_range(0, 4))
        0: in_field = OP_RTYPE;
        1: in_field = OP_BEQ;
        2: in_field = OP_LW;
        3: in_field = OP_SW;
        default: in_field = W'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_sel   = IW'($urandom_range(0, NP - 1));
      cnt_clr   = ($urandom_range(0, 19) == 0);
      tick("rand");
    end
    cfg_we = 0; cnt_clr = 0; in_valid = 0; out_ready = 0;

    // Async reset while a result is held
    send("ar_load", OP_LW);
    chk("ar.tp_valid_before", out_valid, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("ar.tp_valid_async", out_valid, 0);
    check_outputs("ar");
    rst_n = 1;
    out_ready = 1;
    send("ar_after", OP_RTYPE);
    chk("ar.tp_no_hit", out_hit, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
